// File: rtl/pll_lock_sequencer_if.sv
// PLL control/status bundle between the lock sequencer and its environment.
// The slave side is the sequencer; the master side drives the PLL status.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_resetb;
    logic       sys_rst;
    logic       locked;
    logic       lock_timeout;
    logic [7:0] lock_lost_count;

    modport master (
        output pll_lock,
        output relock_req,
        input  pll_resetb,
        input  sys_rst,
        input  locked,
        input  lock_timeout,
        input  lock_lost_count
    );

    modport slave (
        input  pll_lock,
        input  relock_req,
        output pll_resetb,
        output sys_rst,
        output locked,
        output lock_timeout,
        output lock_lost_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer running on the free-running clk16 reference.
// Define PLL_SEQ_TIMEOUT_EN to retry the PLL when lock never arrives.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned LOCK_TIMEOUT  = 65535
) (
    input  logic                 clk16,
    input  logic                 rst_n,
    pll_lock_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
    // The WAIT_LOCK cycle that sees lock_s counts as the first stable cycle.
    localparam logic [15:0] STB_LAST =
        (STABLE_CYCLES > 1) ? 16'(STABLE_CYCLES - 2) : 16'd0;

    if (RESET_CYCLES < 1 || RESET_CYCLES > 255 ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 ||
        LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_cfg
        $error("pll_lock_sequencer: parameter out of range");
    end

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic        sync_q;
    logic        lock_s;
    logic        timeout_hit;

    logic        pll_resetb_q;
    logic        sys_rst_q;
    logic        locked_q;
    logic        lock_timeout_q;
    logic [7:0]  lost_q;

    logic        pll_resetb_d;
    logic        sys_rst_d;
    logic        locked_d;
    logic        lock_timeout_d;
    logic [7:0]  lost_d;

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= bus.pll_lock;
            lock_s <= sync_q;
        end
    end

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);
    assign timeout_hit = (state == WAIT_LOCK) && !lock_s && (cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_PLL;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (bus.relock_req) next_state = RESET_PLL;
                else if (lock_s) next_state = (STABLE_CYCLES == 1) ? RUN : STABLE;
                else if (timeout_hit) next_state = RESET_PLL;
            end
            STABLE: begin
                if (bus.relock_req) next_state = RESET_PLL;
                else if (!lock_s) next_state = WAIT_LOCK;
                else if (cnt == STB_LAST) next_state = RUN;
            end
            RUN: begin
                if (bus.relock_req || !lock_s) next_state = RESET_PLL;
            end
            default: next_state = RESET_PLL;
        endcase
    end

    // Outputs are decoded from next_state so they switch on the entry edge.
    always_comb begin
        pll_resetb_d   = (next_state != RESET_PLL);
        sys_rst_d      = (next_state != RUN);
        locked_d       = (next_state == RUN);
        lost_d         = lost_q;
        lock_timeout_d = lock_timeout_q;
        if (state == RUN && !lock_s && lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
        end
        if (timeout_hit) begin
            lock_timeout_d = 1'b1;
        end
        if (next_state == RUN && state != RUN) begin
            lock_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            pll_resetb_q   <= 1'b0;
            sys_rst_q      <= 1'b1;
            locked_q       <= 1'b0;
            lock_timeout_q <= 1'b0;
            lost_q         <= 8'd0;
        end else begin
            pll_resetb_q   <= pll_resetb_d;
            sys_rst_q      <= sys_rst_d;
            locked_q       <= locked_d;
            lock_timeout_q <= lock_timeout_d;
            lost_q         <= lost_d;
        end
    end

    assign bus.pll_resetb      = pll_resetb_q;
    assign bus.sys_rst         = sys_rst_q;
    assign bus.locked          = locked_q;
    assign bus.lock_timeout    = lock_timeout_q;
    assign bus.lock_lost_count = lost_q;

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: clk16 cycles that pll_resetb is held low per sequence, range 1..255.
REQ-002 SHALL have parameter STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before release, range 1..65535.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum WAIT_LOCK cycles before a retry, range 1..65535.
REQ-004 clk16  in  1  free-running reference clock; the block runs only on this clock, never on the PLL output.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pll_lock  in  1  raw PLL LOCK output, asynchronous to clk16.
REQ-007 relock_req  in  1  single-cycle request to force a full re-sequence.
REQ-008 pll_resetb  out  1  drives PLL RESETB; 0 holds the PLL in reset.
REQ-009 sys_rst  out  1  active-high reset for the PLL-clocked system domain.
REQ-010 locked  out  1  high only in state RUN.
REQ-011 lock_timeout  out  1  sticky flag: a lock timeout has occurred since the last entry to RUN.
REQ-012 lock_lost_count  out  8  saturating count of lock losses while in RUN.

Function
REQ-013 SHALL pass pll_lock through a 2-flop synchronizer; lock_s is the synchronized signal, with 2-cycle latency; no other logic SHALL use raw pll_lock.
REQ-014 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE and RUN, with one shared 16-bit cycle counter cleared on every state entry.
REQ-015 RESET_PLL: pll_resetb=0; after RESET_CYCLES cycles, go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_resetb=1; when lock_s=1, go to STABLE.
REQ-017 STABLE: if lock_s=0, return to WAIT_LOCK with the counter cleared; after lock_s has been 1 for STABLE_CYCLES consecutive cycles, go to RUN.
REQ-018 RUN: sys_rst=0 and locked=1; when lock_s=0, go to RESET_PLL and increment lock_lost_count, saturating at 255.
REQ-019 sys_rst SHALL be 1 in every state except RUN; all outputs SHALL be registered and change on the clock edge that enters the new state.
REQ-020 relock_req=1 in WAIT_LOCK, STABLE or RUN SHALL cause a transition to RESET_PLL; relock_req SHALL be ignored in RESET_PLL and SHALL NOT restart its counter.
REQ-021 If relock_req=1 and lock_s=0 occur in the same RUN cycle, the block SHALL make one transition to RESET_PLL and increment lock_lost_count once.
REQ-022 lock_timeout SHALL clear on entry to RUN only.

Reset
REQ-023 When rst_n=0, the block SHALL asynchronously set: state RESET_PLL, counter 0, synchronizer flops 0, pll_resetb=0, sys_rst=1, locked=0, lock_timeout=0, lock_lost_count=0.
REQ-024 Assertion of rst_n in any state, mid-count included, SHALL abandon the sequence; after deassertion, RESET_PLL SHALL run a full RESET_CYCLES period.

Configuration
REQ-025 With macro PLL_SEQ_TIMEOUT_EN defined: when WAIT_LOCK has lasted LOCK_TIMEOUT cycles without lock_s=1, the block SHALL go to RESET_PLL and set lock_timeout=1.
REQ-026 Without PLL_SEQ_TIMEOUT_EN: WAIT_LOCK SHALL wait indefinitely, lock_timeout SHALL be tied to 0, and LOCK_TIMEOUT SHALL be unused.

Verification
All scenarios use RESET_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32.
REQ-027 Basic sequence: release rst_n; raise pll_lock at cycle 10 and hold it -> pll_resetb rises after 4 cycles; RUN is entered, with sys_rst=0 and locked=1, 2+8 cycles after pll_lock rises.
REQ-028 Glitch rejection: pll_lock high for 5 cycles, then low for 1, then high -> STABLE returns to WAIT_LOCK; sys_rst=0 occurs only 8 clean synchronized cycles after the final rise.
REQ-029 Lock loss: in RUN, drop pll_lock 300 times -> each drop produces sys_rst=1 and pll_resetb=0 for 4 cycles; lock_lost_count ends at 255.
REQ-030 Timeout, macro defined: hold pll_lock=0 -> a RESET_PLL retry every 4+32 cycles and lock_timeout=1; a later lock clears lock_timeout on entry to RUN. Macro undefined: the block stays in WAIT_LOCK and lock_timeout=0.
REQ-031 Collisions: relock_req together with a lock drop in RUN -> lock_lost_count increments by 1; relock_req in RESET_PLL -> RESET_PLL still lasts exactly 4 cycles.
REQ-032 Mid-operation reset: assert rst_n=0 in STABLE -> all outputs take reset values immediately, with lock_lost_count=0.
